// File: rtl/slot_alloc96_pkg.sv
// Shared constants and types for the 96-slot allocator.
// resv_map() builds the reset image of the slot map.
package slot_alloc96_pkg;

    localparam int NSLOTS = 96;
    localparam int SLOT_W = 7;

    typedef logic [SLOT_W-1:0] slot_idx_t;

    localparam slot_idx_t NONE_IDX   = 7'd127;
    localparam slot_idx_t NSLOTS_IDX = 7'd96;

    function automatic logic [NSLOTS-1:0] resv_map(input int unsigned n);
        logic [NSLOTS-1:0] m;
        m = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (i < int'(n)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/slot_alloc96_ffz96.sv
// Find-first-zero over the 96-bit slot map, searching from bit 95 downward.
// Reports NONE_IDX when every slot is in use.
module ffz96
    import slot_alloc96_pkg::*;
(
    input  logic [NSLOTS-1:0] map,
    output slot_idx_t         idx
);

    // Ascending scan, so the last zero seen (highest index) wins.
    always_comb begin
        idx = NONE_IDX;
        for (int i = 0; i < NSLOTS; i++) begin
            if (!map[i]) idx = slot_idx_t'(i);
        end
    end

endmodule

// File: rtl/slot_alloc96.sv
// 96-slot allocator: hands out the highest free slot with a one-cycle
// registered ack, accepts frees, and flags illegal frees stickily.
module slot_alloc96
    import slot_alloc96_pkg::*;
#(
    parameter int unsigned RESV = 0
)
(
    input  logic      rst_i,
    input  logic      clk_i,
    input  logic      alloc_req_i,
    output logic      alloc_ack_o,
    output slot_idx_t alloc_idx_o,
    input  logic      free_i,
    input  slot_idx_t free_idx_i,
    output logic      full_o,
    output logic      empty_o,
    output slot_idx_t count_o,
    output logic      err_o
);

    localparam logic [NSLOTS-1:0] RESV_MAP = resv_map(RESV);

    logic [NSLOTS-1:0] map;
    logic [NSLOTS-1:0] map_nxt;
    slot_idx_t         cand;
    slot_idx_t         count_nxt;
    logic              accept;
    logic              free_ok;
    logic              free_bad;

    ffz96 u_ffz (
        .map (map),
        .idx (cand)
    );

    // The search sees the pre-edge map, where a slot being freed is still
    // set, so it can never be handed out in the same cycle it is released.
    always_comb begin
        accept   = alloc_req_i && (cand != NONE_IDX) && !full_o;
        free_ok  = free_i && (free_idx_i < NSLOTS_IDX) && map[free_idx_i];
        free_bad = free_i && !free_ok;

        map_nxt = map;
        if (accept)  map_nxt[cand]       = 1'b1;
        if (free_ok) map_nxt[free_idx_i] = 1'b0;

        count_nxt = count_o;
        case ({accept, free_ok})
            2'b10:   count_nxt = count_o + 7'd1;
            2'b01:   count_nxt = count_o - 7'd1;
            default: count_nxt = count_o;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            map         <= RESV_MAP;
            count_o     <= slot_idx_t'(RESV);
            alloc_ack_o <= 1'b0;
            alloc_idx_o <= '0;
            err_o       <= 1'b0;
            full_o      <= 1'b0;
            empty_o     <= (RESV == 0);
        end else begin
            map         <= map_nxt;
            count_o     <= count_nxt;
            alloc_ack_o <= accept;
            if (accept) alloc_idx_o <= cand;
            if (free_bad) err_o <= 1'b1;
            full_o      <= (count_nxt == NSLOTS_IDX);
            empty_o     <= (count_nxt == 7'd0);
        end
    end

endmodule
